// File: rtl/tug_match_ctrl_pkg.sv
// Shared types for the tug-of-war match controller: FSM states and winner codes.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        WIN        = 2'd1,
        MATCH_OVER = 2'd2
    } tug_state_e;

    typedef logic [1:0] tug_winner_t;

    localparam tug_winner_t WIN_NONE  = 2'b00;
    localparam tug_winner_t WIN_LEFT  = 2'b01;
    localparam tug_winner_t WIN_RIGHT = 2'b10;

endpackage

// File: rtl/tug_match_ctrl_if.sv
// Player-input / display-output bundle of the match controller.
// The master side drives the press and new_round pulses; the slave side is the controller.
interface tug_match_ctrl_if
    import tug_pkg::*;
#(
    parameter int N_LEDS  = 9,
    parameter int SCORE_W = 3
);
    logic                l_press;
    logic                r_press;
    logic                new_round;
    logic [N_LEDS-1:0]   leds;
    logic [SCORE_W-1:0]  l_score;
    logic [SCORE_W-1:0]  r_score;
    tug_winner_t         winner;
    logic                match_over;

    modport master (
        output l_press, r_press, new_round,
        input  leds, l_score, r_score, winner, match_over
    );

    modport slave (
        input  l_press, r_press, new_round,
        output leds, l_score, r_score, winner, match_over
    );
endinterface

// File: rtl/tug_match_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones; one instance keeps each player's score.
module sat_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/tug_match_ctrl.sv
// Tug-of-war match controller: moves a one-hot rope light, detects round wins at
// either edge, keeps saturating scores and latches match-over at the maximum score.
module tug_match_ctrl
    import tug_pkg::*;
#(
    parameter int N_LEDS  = 9,
    parameter int SCORE_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    tug_match_ctrl_if.slave     bus
);
    localparam int                  POS_W       = $clog2(N_LEDS);
    localparam logic [POS_W-1:0]    POS_LEFT    = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0]    POS_CENTRE  = POS_W'((N_LEDS - 1) / 2);
    localparam logic [N_LEDS-1:0]   LEDS_CENTRE = N_LEDS'(1) << ((N_LEDS - 1) / 2);
    // A round win from this score reaches the maximum and ends the match.
    localparam logic [SCORE_W-1:0]  MATCH_POINT = SCORE_W'((2 ** SCORE_W) - 2);

    tug_state_e          state_q;
    logic [POS_W-1:0]    pos_q;
    logic [N_LEDS-1:0]   leds_q;
    tug_winner_t         winner_q;
    logic                match_over_q;

    logic [SCORE_W-1:0]  l_score;
    logic [SCORE_W-1:0]  r_score;
    logic                take_presses;
    logic                l_only;
    logic                r_only;
    logic                l_inc;
    logic                r_inc;

    assign take_presses = (state_q == PLAY) && !bus.new_round;
    assign l_only       = bus.l_press && !bus.r_press;
    assign r_only       = bus.r_press && !bus.l_press;
    assign l_inc        = take_presses && l_only && (pos_q == POS_LEFT);
    assign r_inc        = take_presses && r_only && (pos_q == '0);

    sat_counter #(.WIDTH(SCORE_W)) u_l_score (
        .clk   (clk),
        .reset (reset),
        .inc   (l_inc),
        .count (l_score)
    );

    sat_counter #(.WIDTH(SCORE_W)) u_r_score (
        .clk   (clk),
        .reset (reset),
        .inc   (r_inc),
        .count (r_score)
    );

    // leds_q shifts in lockstep with pos_q so the light stays one-hot without a decoder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= PLAY;
            pos_q        <= POS_CENTRE;
            leds_q       <= LEDS_CENTRE;
            winner_q     <= WIN_NONE;
            match_over_q <= 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (bus.new_round) begin
                        pos_q  <= POS_CENTRE;
                        leds_q <= LEDS_CENTRE;
                    end else if (l_inc) begin
                        winner_q <= WIN_LEFT;
                        if (l_score == MATCH_POINT) begin
                            state_q      <= MATCH_OVER;
                            match_over_q <= 1'b1;
                        end else begin
                            state_q <= WIN;
                        end
                    end else if (r_inc) begin
                        winner_q <= WIN_RIGHT;
                        if (r_score == MATCH_POINT) begin
                            state_q      <= MATCH_OVER;
                            match_over_q <= 1'b1;
                        end else begin
                            state_q <= WIN;
                        end
                    end else if (l_only) begin
                        pos_q  <= pos_q + 1'b1;
                        leds_q <= leds_q << 1;
                    end else if (r_only) begin
                        pos_q  <= pos_q - 1'b1;
                        leds_q <= leds_q >> 1;
                    end
                end
                WIN: begin
                    if (bus.new_round) begin
                        state_q  <= PLAY;
                        pos_q    <= POS_CENTRE;
                        leds_q   <= LEDS_CENTRE;
                        winner_q <= WIN_NONE;
                    end
                end
                MATCH_OVER: begin
                end
                default: begin
                    state_q <= PLAY;
                end
            endcase
        end
    end

    assign bus.leds       = leds_q;
    assign bus.l_score    = l_score;
    assign bus.r_score    = r_score;
    assign bus.winner     = winner_q;
    assign bus.match_over = match_over_q;
endmodule

// File: tb/tb_tug_match_ctrl.sv
// Directed bench for tug_match_ctrl with hand-computed expectations, one task per scenario.
module tb_tug_match_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    tug_match_ctrl_if #(.N_LEDS(9), .SCORE_W(3)) bus ();

    tug_match_ctrl #(.N_LEDS(9), .SCORE_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then leave the bench 1 time unit after the edge.
    task automatic cycle(input logic l, input logic r, input logic nr);
        bus.l_press   = l;
        bus.r_press   = r;
        bus.new_round = nr;
        @(posedge clk);
        #1;
        bus.l_press   = 1'b0;
        bus.r_press   = 1'b0;
        bus.new_round = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        total++; if (bus.leds !== 9'b000010000) begin bad++; $display("FAIL reset_leds got=%b want=%b", bus.leds, 9'b000010000); end
        total++; if (bus.l_score !== 3'd0) begin bad++; $display("FAIL reset_l_score got=%0d want=0", bus.l_score); end
        total++; if (bus.r_score !== 3'd0) begin bad++; $display("FAIL reset_r_score got=%0d want=0", bus.r_score); end
        total++; if (bus.winner !== 2'b00) begin bad++; $display("FAIL reset_winner got=%b want=00", bus.winner); end
        total++; if (bus.match_over !== 1'b0) begin bad++; $display("FAIL reset_match_over got=%b want=0", bus.match_over); end
        $display("reset: leds=%b l=%0d r=%0d winner=%b mo=%b", bus.leds, bus.l_score, bus.r_score, bus.winner, bus.match_over);
    endtask

    task automatic test_left_win();
        logic [8:0] walk [4];
        walk[0] = 9'b000100000;
        walk[1] = 9'b001000000;
        walk[2] = 9'b010000000;
        walk[3] = 9'b100000000;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            total++; if (bus.leds !== walk[i]) begin bad++; $display("FAIL left_walk%0d got=%b want=%b", i, bus.leds, walk[i]); end
            $display("left press %0d: leds=%b", i, bus.leds);
        end
        cycle(1'b1, 1'b0, 1'b0);
        total++; if (bus.winner !== 2'b01) begin bad++; $display("FAIL left_win_winner got=%b want=01", bus.winner); end
        total++; if (bus.l_score !== 3'd1) begin bad++; $display("FAIL left_win_score got=%0d want=1", bus.l_score); end
        total++; if (bus.r_score !== 3'd0) begin bad++; $display("FAIL left_win_loser got=%0d want=0", bus.r_score); end
        total++; if (bus.match_over !== 1'b0) begin bad++; $display("FAIL left_win_mo got=%b want=0", bus.match_over); end
        $display("left win: leds=%b winner=%b l=%0d", bus.leds, bus.winner, bus.l_score);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        total++; if (bus.leds !== 9'b100000000) begin bad++; $display("FAIL win_hold_leds got=%b want=%b", bus.leds, 9'b100000000); end
        total++; if (bus.l_score !== 3'd1) begin bad++; $display("FAIL win_hold_score got=%0d want=1", bus.l_score); end
        total++; if (bus.winner !== 2'b01) begin bad++; $display("FAIL win_hold_winner got=%b want=01", bus.winner); end
        $display("win hold: leds=%b winner=%b l=%0d", bus.leds, bus.winner, bus.l_score);
    endtask

    task automatic test_new_round();
        cycle(1'b0, 1'b0, 1'b1);
        total++; if (bus.leds !== 9'b000010000) begin bad++; $display("FAIL new_round_leds got=%b want=%b", bus.leds, 9'b000010000); end
        total++; if (bus.winner !== 2'b00) begin bad++; $display("FAIL new_round_winner got=%b want=00", bus.winner); end
        $display("new round: leds=%b winner=%b", bus.leds, bus.winner);
        cycle(1'b1, 1'b0, 1'b0);
        total++; if (bus.leds !== 9'b000100000) begin bad++; $display("FAIL replay_move got=%b want=%b", bus.leds, 9'b000100000); end
        $display("replay move: leds=%b", bus.leds);
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_tie_and_priority();
        cycle(1'b1, 1'b1, 1'b0);
        total++; if (bus.leds !== 9'b000010000) begin bad++; $display("FAIL tie_leds got=%b want=%b", bus.leds, 9'b000010000); end
        $display("tie: leds=%b", bus.leds);
        cycle(1'b0, 1'b1, 1'b0);
        total++; if (bus.leds !== 9'b000001000) begin bad++; $display("FAIL right_step got=%b want=%b", bus.leds, 9'b000001000); end
        $display("right step: leds=%b", bus.leds);
        cycle(1'b0, 1'b1, 1'b1);
        total++; if (bus.leds !== 9'b000010000) begin bad++; $display("FAIL new_round_priority got=%b want=%b", bus.leds, 9'b000010000); end
        $display("new_round priority: leds=%b", bus.leds);
    endtask

    task automatic test_right_match();
        for (int w = 1; w <= 7; w++) begin
            repeat (5) cycle(1'b0, 1'b1, 1'b0);
            total++; if (bus.r_score !== 3'(w)) begin bad++; $display("FAIL right_score%0d got=%0d want=%0d", w, bus.r_score, w); end
            total++; if (bus.winner !== 2'b10) begin bad++; $display("FAIL right_winner%0d got=%b want=10", w, bus.winner); end
            total++; if (bus.match_over !== (w == 7)) begin bad++; $display("FAIL right_mo%0d got=%b want=%b", w, bus.match_over, (w == 7)); end
            total++; if (bus.leds !== 9'b000000001) begin bad++; $display("FAIL right_edge%0d got=%b want=%b", w, bus.leds, 9'b000000001); end
            $display("right win %0d: r=%0d winner=%b mo=%b leds=%b", w, bus.r_score, bus.winner, bus.match_over, bus.leds);
            if (w < 7) cycle(1'b0, 1'b0, 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        total++; if (bus.leds !== 9'b000000001) begin bad++; $display("FAIL mo_hold_leds got=%b want=%b", bus.leds, 9'b000000001); end
        total++; if (bus.r_score !== 3'd7) begin bad++; $display("FAIL mo_hold_r got=%0d want=7", bus.r_score); end
        total++; if (bus.l_score !== 3'd1) begin bad++; $display("FAIL mo_hold_l got=%0d want=1", bus.l_score); end
        total++; if (bus.winner !== 2'b10) begin bad++; $display("FAIL mo_hold_winner got=%b want=10", bus.winner); end
        total++; if (bus.match_over !== 1'b1) begin bad++; $display("FAIL mo_hold_mo got=%b want=1", bus.match_over); end
        $display("match over hold: leds=%b l=%0d r=%0d winner=%b mo=%b", bus.leds, bus.l_score, bus.r_score, bus.winner, bus.match_over);
    endtask

    task automatic test_async_reset();
        #2 reset = 1'b1;
        #1;
        total++; if (bus.match_over !== 1'b0) begin bad++; $display("FAIL areset_mo_clear got=%b want=0", bus.match_over); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (5) cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b1);
        end
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        total++; if (bus.l_score !== 3'd3) begin bad++; $display("FAIL pre_reset_l got=%0d want=3", bus.l_score); end
        total++; if (bus.leds !== 9'b000000100) begin bad++; $display("FAIL pre_reset_leds got=%b want=%b", bus.leds, 9'b000000100); end
        $display("before async reset: leds=%b l=%0d", bus.leds, bus.l_score);
        #2 reset = 1'b1;
        #1;
        total++; if (bus.leds !== 9'b000010000) begin bad++; $display("FAIL areset_leds got=%b want=%b", bus.leds, 9'b000010000); end
        total++; if (bus.l_score !== 3'd0) begin bad++; $display("FAIL areset_l got=%0d want=0", bus.l_score); end
        total++; if (bus.winner !== 2'b00) begin bad++; $display("FAIL areset_winner got=%b want=00", bus.winner); end
        $display("async reset mid-round: leds=%b l=%0d winner=%b", bus.leds, bus.l_score, bus.winner);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        total++; if (bus.leds !== 9'b000010000) begin bad++; $display("FAIL wreset_leds got=%b want=%b", bus.leds, 9'b000010000); end
        total++; if (bus.winner !== 2'b00) begin bad++; $display("FAIL wreset_winner got=%b want=00", bus.winner); end
        total++; if (bus.l_score !== 3'd0) begin bad++; $display("FAIL wreset_l got=%0d want=0", bus.l_score); end
        $display("async reset mid-win: leds=%b l=%0d winner=%b", bus.leds, bus.l_score, bus.winner);
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        total++; if (bus.leds !== 9'b000100000) begin bad++; $display("FAIL post_reset_move got=%b want=%b", bus.leds, 9'b000100000); end
        $display("after reset move: leds=%b", bus.leds);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b1;
        bus.l_press   = 1'b0;
        bus.r_press   = 1'b0;
        bus.new_round = 1'b0;
        test_reset();
        test_left_win();
        test_new_round();
        test_tie_and_priority();
        test_right_match();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
